// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 STATUS/CAUSE/EPC owner with interrupt sync, exception priority and pipeline redirect.
module cp0_exc_ctrl #(
  parameter int          NUM_INT      = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0008,
  parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] int_req,
  input  logic               id_eret,
  input  logic               id_syscall,
  input  logic               id_unknown,
  input  logic               exe_overflow,
  input  logic [31:0]        id_pc,
  input  logic [31:0]        exe_pc,
  input  logic               mtc0_we,
  input  logic [4:0]         mtc0_addr,
  input  logic [31:0]        mtc0_data,
  input  logic [4:0]         mfc0_addr,
  output logic [31:0]        mfc0_data,
  output logic [31:0]        status_out,
  output logic [31:0]        epc_out,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic [4:0]         exc_code
);
  logic [NUM_INT-1:0] synced, ip, im;
  logic               ie, exl, int_fire, exc, eret_take, wr_status, wr_epc;
  logic [4:0]         code, cause_code;
  logic [31:0]        epc, cause_val;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign synced = int_req;
  end else begin : g_sync
    logic [NUM_INT-1:0] chain [SYNC_STAGES];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      end else begin
        chain[0] <= int_req;
        for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      end
    end
    assign synced = chain[SYNC_STAGES-1];
  end
  always_comb begin
    int_fire    = ie & ~exl & |(ip & im);
    exc         = ~rst & (exe_overflow | id_unknown | id_syscall | int_fire);
    eret_take   = ~rst & id_eret & ~exc;
    code        = exe_overflow ? 5'd12 : id_unknown ? 5'd10 : id_syscall ? 5'd8 : 5'd0;
    redirect    = exc | eret_take;
    redirect_pc = eret_take ? epc : EXC_VECTOR;
    exc_code    = exc ? code : 5'd0;
    wr_status   = mtc0_we & (mtc0_addr == 5'd12);
    wr_epc      = mtc0_we & (mtc0_addr == 5'd14);
  end
  always_comb begin
    status_out               = '0;
    status_out[0]            = ie;
    status_out[1]            = exl;
    status_out[8+:NUM_INT]   = im;
    cause_val                = '0;
    cause_val[6:2]           = cause_code;
    cause_val[8+:NUM_INT]    = ip;
    epc_out                  = epc;
    mfc0_data                = mfc0_addr == 5'd12 ? status_out :
                               mfc0_addr == 5'd13 ? cause_val :
                               mfc0_addr == 5'd14 ? epc : 32'h0;
  end
  // Events override EXL/EPC; a simultaneous mtc0 still lands in IE/IM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie         <= STATUS_RESET[0];
      exl        <= STATUS_RESET[1];
      im         <= STATUS_RESET[8+:NUM_INT];
      ip         <= '0;
      cause_code <= '0;
      epc        <= '0;
    end else begin
      ie         <= wr_status ? mtc0_data[0] : ie;
      im         <= wr_status ? mtc0_data[8+:NUM_INT] : im;
      exl        <= exc ? 1'b1 : eret_take ? 1'b0 : wr_status ? mtc0_data[1] : exl;
      ip         <= synced;
      cause_code <= exc ? code : cause_code;
      epc        <= (exc & ~exl) ? (exe_overflow ? exe_pc : id_pc) : wr_epc ? mtc0_data : epc;
    end
  end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed self-checking bench for cp0_exc_ctrl (default and 8-line configurations).
module tb_cp0_exc_ctrl;
  logic        clk = 0, rst = 1;
  logic [5:0]  int_req = 0;
  logic [7:0]  int_req8 = 0;
  logic        id_eret = 0, id_syscall = 0, id_unknown = 0, exe_overflow = 0;
  logic [31:0] id_pc = 0, exe_pc = 0, mtc0_data = 0;
  logic        mtc0_we = 0, mtc0_we8 = 0;
  logic [4:0]  mtc0_addr = 0, mfc0_addr = 0;
  logic [31:0] mfc0_data, status_out, epc_out, redirect_pc;
  logic [31:0] mfc0_data8, status8, epc8, redirect_pc8;
  logic        redirect, redirect8;
  logic [4:0]  exc_code, exc_code8;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .int_req(int_req), .id_eret(id_eret), .id_syscall(id_syscall),
    .id_unknown(id_unknown), .exe_overflow(exe_overflow), .id_pc(id_pc), .exe_pc(exe_pc),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data), .mfc0_addr(mfc0_addr),
    .mfc0_data(mfc0_data), .status_out(status_out), .epc_out(epc_out), .redirect(redirect),
    .redirect_pc(redirect_pc), .exc_code(exc_code)
  );

  cp0_exc_ctrl #(.NUM_INT(8)) dut8 (
    .clk(clk), .rst(rst), .int_req(int_req8), .id_eret(1'b0), .id_syscall(1'b0),
    .id_unknown(1'b0), .exe_overflow(1'b0), .id_pc(id_pc), .exe_pc(32'h0),
    .mtc0_we(mtc0_we8), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data), .mfc0_addr(mfc0_addr),
    .mfc0_data(mfc0_data8), .status_out(status8), .epc_out(epc8), .redirect(redirect8),
    .redirect_pc(redirect_pc8), .exc_code(exc_code8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_status", status_out, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_redirect", {31'b0, redirect}, 32'h0);
    chk("rst_pc", redirect_pc, 32'h8);
    chk("rst_code", {27'b0, exc_code}, 32'h0);
    rst = 0;
    tick();
    mtc0_we = 1; mtc0_addr = 12; mtc0_data = 32'h0000_0101;
    tick();
    mtc0_we = 0;
    mfc0_addr = 12;
    #1;
    chk("mtc0_status", status_out, 32'h0000_0101);
    chk("mfc0_status", mfc0_data, 32'h0000_0101);
    int_req = 6'h01; id_pc = 32'h40;
    tick();
    tick();
    chk("int_lat2", {31'b0, redirect}, 32'h0);
    tick();
    chk("int_lat3", {31'b0, redirect}, 32'h1);
    chk("int_pc", redirect_pc, 32'h8);
    chk("int_code", {27'b0, exc_code}, 32'h0);
    tick();
    mfc0_addr = 13;
    #1;
    chk("int_epc", epc_out, 32'h40);
    chk("int_status", status_out, 32'h0000_0103);
    chk("int_cause", mfc0_data, 32'h0000_0100);
    chk("exl_blocks_int", {31'b0, redirect}, 32'h0);
    id_eret = 1; id_pc = 32'h50;
    #1;
    chk("eret_redirect", {31'b0, redirect}, 32'h1);
    chk("eret_pc", redirect_pc, 32'h40);
    tick();
    id_eret = 0; id_pc = 32'h60; int_req = 0;
    #1;
    chk("eret_exl_clr", status_out, 32'h0000_0101);
    chk("retake_redirect", {31'b0, redirect}, 32'h1);
    chk("retake_pc", redirect_pc, 32'h8);
    tick();
    chk("retake_epc", epc_out, 32'h60);
    tick();
    tick();
    chk("ip_cleared", mfc0_data, 32'h0);
    id_eret = 1;
    tick();
    id_eret = 0;
    #1;
    chk("eret2_status", status_out, 32'h0000_0101);
    chk("eret2_noint", {31'b0, redirect}, 32'h0);
    exe_overflow = 1; exe_pc = 32'h100; id_syscall = 1; id_pc = 32'h104;
    #1;
    chk("ovf_code", {27'b0, exc_code}, 32'd12);
    chk("ovf_pc", redirect_pc, 32'h8);
    tick();
    exe_overflow = 0; id_syscall = 0;
    #1;
    chk("ovf_epc", epc_out, 32'h100);
    chk("ovf_cause", mfc0_data, 32'h0000_0030);
    id_syscall = 1; id_pc = 32'h200;
    mtc0_we = 1; mtc0_addr = 12; mtc0_data = 32'h0000_0001;
    #1;
    chk("sys_redirect", {31'b0, redirect}, 32'h1);
    chk("sys_code", {27'b0, exc_code}, 32'd8);
    tick();
    id_syscall = 0; mtc0_we = 0;
    #1;
    chk("sys_cause", mfc0_data, 32'h0000_0020);
    chk("sys_epc_keep", epc_out, 32'h100);
    chk("mtc0_vs_exl", status_out, 32'h0000_0003);
    exe_overflow = 1; exe_pc = 32'h300; id_eret = 1;
    #1;
    chk("ovf_eret_pc", redirect_pc, 32'h8);
    chk("ovf_eret_code", {27'b0, exc_code}, 32'd12);
    tick();
    exe_overflow = 0; id_eret = 0;
    #1;
    chk("ovf_eret_exl", status_out, 32'h0000_0003);
    chk("ovf_eret_epc", epc_out, 32'h100);
    mtc0_we = 1; mtc0_addr = 13; mtc0_data = 32'hFFFF_FFFF;
    tick();
    mtc0_addr = 14; mtc0_data = 32'h0000_1234;
    #1;
    chk("cause_ro", mfc0_data, 32'h0000_0030);
    tick();
    mtc0_we = 0; mfc0_addr = 5;
    #1;
    chk("mtc0_epc", epc_out, 32'h0000_1234);
    chk("mfc0_unmapped", mfc0_data, 32'h0);
    id_syscall = 1;
    #3;
    rst = 1;
    #1;
    chk("async_status", status_out, 32'h0);
    chk("async_epc", epc_out, 32'h0);
    chk("async_redirect", {31'b0, redirect}, 32'h0);
    chk("async_code", {27'b0, exc_code}, 32'h0);
    id_syscall = 0;
    tick();
    rst = 0;
    tick();
    mtc0_we8 = 1; mtc0_addr = 12; mtc0_data = 32'h0000_8001;
    tick();
    mtc0_we8 = 0; int_req8 = 8'h80; id_pc = 32'h500; mfc0_addr = 13;
    tick();
    tick();
    chk("n8_lat2", {31'b0, redirect8}, 32'h0);
    tick();
    chk("n8_redirect", {31'b0, redirect8}, 32'h1);
    chk("n8_cause_ip7", mfc0_data8, 32'h0000_8000);
    tick();
    chk("n8_status", status8, 32'h0000_8003);
    chk("n8_epc", epc8, 32'h500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Parametrised CP0 exception/status controller for the pipelined MIPS core; successor to the combinational STATUS next-value logic.
- Owns the STATUS, CAUSE and EPC registers.
- Synchronises and masks NUM_INT hardware interrupt lines and prioritises them against synchronous exceptions from ID and EXE.
- Drives the pipeline redirect (exception vector or EPC on eret) and serves mtc0/mfc0.

Parameters:
NUM_INT, 6, number of hardware interrupt lines (1..8); mapped to STATUS.IM[8+:NUM_INT] and CAUSE.IP[8+:NUM_INT]
SYNC_STAGES, 2, flops on each int_req line (0 = none)
EXC_VECTOR, 32'h0000_0008, redirect target for any exception or interrupt
STATUS_RESET, 32'h0000_0000, STATUS value after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
int_req  in  NUM_INT  level-sensitive external interrupt requests
id_eret  in  1  eret decoded in ID
id_syscall  in  1  syscall decoded in ID
id_unknown  in  1  reserved instruction in ID
exe_overflow  in  1  arithmetic overflow in EXE
id_pc  in  32  PC of instruction in ID
exe_pc  in  32  PC of instruction in EXE
mtc0_we  in  1  CP0 write strobe
mtc0_addr  in  5  CP0 register number (12 STATUS, 13 CAUSE, 14 EPC)
mtc0_data  in  32  write data
mfc0_addr  in  5  read register number
mfc0_data  out  32  read data, combinational from registered state; 0 for unmapped numbers
status_out  out  32  current STATUS
epc_out  out  32  current EPC
redirect  out  1  combinational: flush pipeline and fetch redirect_pc this cycle
redirect_pc  out  32  EXC_VECTOR on exception/interrupt, EPC on eret
exc_code  out  5  combinational code of the event being taken (valid when redirect=1)

Behaviour:
- Reset (async):
  - STATUS=STATUS_RESET, CAUSE=0, EPC=0, synchroniser flops=0.
  - redirect=0, redirect_pc=EXC_VECTOR, exc_code=0.
- STATUS fields: bit0 IE, bit1 EXL, IM[8+:NUM_INT]; all other bits read 0 and ignore writes.
- CAUSE fields: ExcCode[6:2], IP[8+:NUM_INT]; software cannot write CAUSE (mtc0 to 13 ignored).
- Interrupt path:
  - int_req passes through SYNC_STAGES flops; IP is loaded every cycle with the synchronised value (level, non-sticky).
  - int_fire = IE & ~EXL & |(IP & IM).
- Priority, highest first: exe_overflow (code 12), id_unknown (10), id_syscall (8), int_fire (0), id_eret.
  - Only the highest active event is acted on in a cycle.
  - id_syscall, id_unknown and id_eret are mutually exclusive by decode.
- Exception or interrupt taken (combinational redirect=1, redirect_pc=EXC_VECTOR); at the next edge:
  - ExcCode <= code; EXL <= 1.
  - EPC <= exe_pc for overflow; EPC <= id_pc for all others, only if EXL was 0. If EXL was already 1, EPC is unchanged and ExcCode is still updated.
- Interrupts are never taken while EXL=1 or IE=0; they remain visible in IP.
- eret, with no higher event active: redirect=1, redirect_pc=EPC; at the next edge EXL <= 0.
  - If an interrupt is pending during eret while EXL=1, it is not taken that cycle. It is taken the first cycle after EXL clears, if still pending.
- exe_overflow with id_eret in the same cycle: overflow wins, EXL stays/sets 1, eret discarded (it is flushed).
- mtc0:
  - Writes STATUS/EPC at the edge when mtc0_we=1.
  - If an exception or eret updates the same register in that cycle, the event wins field-by-field for EXL/EPC; the write still applies to IE/IM.
- Latency:
  - redirect is asserted in the same cycle as the causing input.
  - State and mfc0_data reflect the event from the cycle after the edge.
  - Interrupt visibility lags int_req by SYNC_STAGES cycles.
- Reset asserted mid-operation: state clears immediately and independently of clk; redirect drops to 0 combinationally.

Test Plan:
- Reset, then mtc0 STATUS=32'h0000_0101 (IE=1, IM0=1); int_req[0]=1 → redirect=1 with redirect_pc=32'h8 exactly 2+1 cycles later. id_pc=32'h40 → EPC=32'h40, ExcCode=0, STATUS=32'h0000_0103 after the edge.
- While EXL=1, int_req[0] held high and eret issued → redirect_pc=EPC, EXL=0 next cycle. Interrupt retaken the following cycle with the new EPC=id_pc.
- exe_overflow=1 (exe_pc=32'h100) and id_syscall=1 (id_pc=32'h104) together → exc_code=12, EPC=32'h100.
- With EXL=1, id_syscall=1 → redirect=1, ExcCode=8, EPC unchanged.
- exe_overflow and id_eret in the same cycle → redirect_pc=32'h8, EXL=1. Also: mtc0 to CAUSE with data 32'hFFFF_FFFF → CAUSE unchanged.
- Assert rst between clock edges with EXL=1 and EPC≠0 → STATUS=STATUS_RESET, EPC=0, redirect=0 immediately. With NUM_INT=8, int_req[7] with IM7=1 fires with IP bit 15 set.
